// File: rtl/fb_pipeline_ctrl.sv
// fb_pipeline_ctrl
// ----------------
// Stall / flush controller for a classic five-stage pipeline. It arbitrates
// between data-memory wait states, taken-branch redirects and load-use
// hazards. It produces the register load enables and clear strobes for the
// pipeline registers.
//
// Parameter
//   FLUSH_CYCLES   extra IF/ID flush cycles after a taken-branch redirect (0..3)
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous, active-low reset
//   lock           load-use hazard request from the hazard detection unit
//   branch_taken   branch/jump resolved taken in EX this cycle
//   mem_req        MEM stage has a data-memory access this cycle
//   mem_ready      data memory completes the access this cycle
//   pc_write       PC register load enable
//   if_id_write    IF/ID register load enable
//   if_id_flush    IF/ID register cleared to NOP
//   id_ex_flush    ID/EX register cleared to a bubble
//   ex_mem_write   EX/MEM and MEM/WB load enable
//   state          current FSM state (RUN=0, MEM_WAIT=1, FLUSH=2)
//   stall_cycles   number of cycles with pc_write low
//
// Build option
//   FB_STALL_CNT_EN  when defined, stall_cycles is a saturating counter of
//                    cycles with pc_write low. When undefined, stall_cycles
//                    is tied to zero and no counter is built.

module fb_pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lock,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_write,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] fcnt;
    logic [1:0] fcnt_nxt;

    logic freeze;
    logic redirect;
    logic bubble;

    // Decode which event owns this cycle. A pending memory access freezes
    // everything. Once memory is ready in MEM_WAIT, the cycle behaves like
    // RUN without the memory term. In FLUSH, branch and lock come from the
    // wrong path, so they are never decoded there.
    always_comb begin
        freeze   = 1'b0;
        redirect = 1'b0;
        bubble   = 1'b0;
        case (cur_state)
            RUN: begin
                freeze   = mem_req && !mem_ready;
                redirect = !freeze && branch_taken;
                bubble   = !freeze && !branch_taken && lock;
            end
            MEM_WAIT: begin
                freeze   = !mem_ready;
                redirect = mem_ready && branch_taken;
                bubble   = mem_ready && !branch_taken && lock;
            end
            FLUSH: begin
                freeze   = mem_req && !mem_ready;
            end
            default: begin
                freeze   = 1'b0;
            end
        endcase
    end

    // State register. Reset clears the flush counter, so a reset taken
    // mid-FLUSH leaves no pending flush behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= RUN;
            fcnt      <= 2'd0;
        end else begin
            cur_state <= nxt_state;
            fcnt      <= fcnt_nxt;
        end
    end

    // Next-state logic. A redirect only enters FLUSH when extra flush
    // cycles are configured. FLUSH leaves on the cycle the counter sits
    // at 1. A memory freeze inside FLUSH holds both the state and the count.
    always_comb begin
        nxt_state = cur_state;
        fcnt_nxt  = fcnt;
        case (cur_state)
            RUN, MEM_WAIT: begin
                if (freeze) begin
                    nxt_state = MEM_WAIT;
                end else if (redirect && (FLUSH_INIT != 2'd0)) begin
                    nxt_state = FLUSH;
                    fcnt_nxt  = FLUSH_INIT;
                end else begin
                    nxt_state = RUN;
                end
            end
            FLUSH: begin
                if (!freeze) begin
                    if (fcnt <= 2'd1) begin
                        nxt_state = RUN;
                        fcnt_nxt  = 2'd0;
                    end else begin
                        fcnt_nxt  = fcnt - 2'd1;
                    end
                end
            end
            default: begin
                nxt_state = RUN;
                fcnt_nxt  = 2'd0;
            end
        endcase
    end

    // Output logic. Reset forces both clears on and all enables off, so the
    // pipeline registers fill with bubbles while rst_n is low.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b0;
        if (!rst_n) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
        end else if (cur_state == FLUSH) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            ex_mem_write = 1'b1;
        end else if (redirect) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
        end else if (bubble) begin
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
        end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
        end
    end

    assign state = cur_state;

`ifdef FB_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fb_pipeline_ctrl.sv
// tb_fb_pipeline_ctrl
// -------------------
// Self-checking bench for fb_pipeline_ctrl, built with FLUSH_CYCLES=2.
// A fixed vector table covers the main event orderings. Hand-written
// sequences cover asynchronous reset and the memory-wait stall count.
// A long random run is checked against a small reference model. The model
// tracks only "waiting for memory", "flush cycles left" and the stall total.
// Output vectors are written as {pc_write, if_id_write, if_id_flush,
// id_ex_flush, ex_mem_write}.

module tb_fb_pipeline_ctrl;

    localparam int FC = 2;
`ifdef FB_STALL_CNT_EN
    localparam logic [31:0] ON = 32'd1;
`else
    localparam logic [31:0] ON = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_write;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    int checks = 0;
    int fails  = 0;

    bit          m_waiting = 1'b0;
    int          m_flush_left = 0;
    logic [31:0] m_stall = 32'd0;

    typedef struct {
        bit         l;
        bit         b;
        bit         rq;
        bit         rd;
        logic [4:0] eo;
        logic [1:0] es;
    } vec_t;

    vec_t tbl[23];

    always #5 clk = ~clk;

    fb_pipeline_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lock         (lock),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .state        (state),
        .stall_cycles (stall_cycles)
    );

    // Reference model: the pipeline is frozen while memory is outstanding.
    // A live redirect opens FC flush cycles. Otherwise the hazard inputs pick
    // one of bubble or normal advance.
    function automatic bit modelFrozen(input bit rq, input bit rd);
        return m_waiting ? !rd : (rq && !rd);
    endfunction

    function automatic logic [4:0] modelOut(input bit l, input bit b, input bit rq, input bit rd);
        if (modelFrozen(rq, rd)) return 5'b00000;
        if (m_flush_left > 0)    return 5'b11101;
        if (b)                   return 5'b11111;
        if (l)                   return 5'b00011;
        return 5'b11001;
    endfunction

    function automatic logic [1:0] modelState();
        if (m_waiting) return 2'd1;
        if (m_flush_left > 0) return 2'd2;
        return 2'd0;
    endfunction

    task automatic modelStep(input logic [4:0] o, input bit b, input bit rq, input bit rd);
        if (!o[4] && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + ON;
        if (modelFrozen(rq, rd)) begin
            if (m_flush_left == 0) m_waiting = 1'b1;
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else begin
            m_waiting = 1'b0;
            if (b) m_flush_left = FC;
        end
    endtask

    task automatic modelReset();
        m_waiting    = 1'b0;
        m_flush_left = 0;
        m_stall      = 32'd0;
    endtask

    // Drive one cycle's inputs shortly after the rising edge, then let the
    // combinational outputs settle well before the next edge.
    task automatic applyStimulus(input bit l, input bit b, input bit rq, input bit rd);
        @(posedge clk);
        #1;
        lock         = l;
        branch_taken = b;
        mem_req      = rq;
        mem_ready    = rd;
        #3;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] eo, input logic [1:0] es, input logic [31:0] ecnt);
        checks += 3;
        if ({pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write} !== eo) begin
            fails++;
            $display("[TB] FAIL %s outputs got %b expected %b", name,
                     {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}, eo);
        end
        if (state !== es) begin
            fails++;
            $display("[TB] FAIL %s state got %0d expected %0d", name, state, es);
        end
        if (stall_cycles !== ecnt) begin
            fails++;
            $display("[TB] FAIL %s stall_cycles got %0d expected %0d", name, stall_cycles, ecnt);
        end
    endtask

    // One cycle checked against hand-derived constants, keeping the model in step.
    task automatic handCycle(input string name, input bit l, input bit b, input bit rq, input bit rd,
                             input logic [4:0] eo, input logic [1:0] es, input logic [31:0] ecnt);
        applyStimulus(l, b, rq, rd);
        checkOutput(name, eo, es, ecnt);
        modelStep(modelOut(l, b, rq, rd), b, rq, rd);
    endtask

    // One cycle checked against the reference model.
    task automatic modelCycle(input string name, input bit l, input bit b, input bit rq, input bit rd);
        logic [4:0] eo;
        applyStimulus(l, b, rq, rd);
        eo = modelOut(l, b, rq, rd);
        checkOutput(name, eo, modelState(), m_stall);
        modelStep(eo, b, rq, rd);
    endtask

    initial begin
        // {lock, branch, mem_req, mem_ready, outputs, state}
        tbl = '{
            '{0, 0, 0, 0, 5'b11001, 2'd0},  // first edge after reset: advance
            '{1, 0, 0, 0, 5'b00011, 2'd0},  // load-use bubble
            '{0, 0, 0, 0, 5'b11001, 2'd0},
            '{0, 0, 1, 0, 5'b00000, 2'd0},  // memory wait begins
            '{1, 1, 1, 0, 5'b00000, 2'd1},  // hazards ignored while frozen
            '{0, 0, 1, 0, 5'b00000, 2'd1},
            '{0, 0, 1, 1, 5'b11001, 2'd1},  // ready cycle advances
            '{0, 0, 0, 0, 5'b11001, 2'd0},
            '{1, 1, 0, 0, 5'b11111, 2'd0},  // branch beats lock
            '{1, 0, 0, 0, 5'b11101, 2'd2},  // lock on wrong path ignored
            '{0, 0, 0, 0, 5'b11101, 2'd2},
            '{0, 0, 0, 0, 5'b11001, 2'd0},
            '{0, 1, 0, 0, 5'b11111, 2'd0},
            '{0, 0, 1, 0, 5'b00000, 2'd2},  // freeze inside FLUSH holds count
            '{0, 0, 0, 0, 5'b11101, 2'd2},
            '{0, 0, 0, 0, 5'b11101, 2'd2},
            '{0, 0, 1, 0, 5'b00000, 2'd0},
            '{0, 1, 1, 1, 5'b11111, 2'd1},  // redirect on the ready cycle
            '{0, 0, 0, 0, 5'b11101, 2'd2},
            '{0, 0, 0, 0, 5'b11101, 2'd2},
            '{0, 0, 1, 0, 5'b00000, 2'd0},
            '{1, 0, 1, 1, 5'b00011, 2'd1},  // lock on the ready cycle
            '{0, 0, 0, 0, 5'b11001, 2'd0}
        };

        // Reset holds outputs in the bubble-fill pattern, even with busy inputs.
        lock = 1'b1; branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        #7;
        checkOutput("reset_hold", 5'b00110, 2'd0, 32'd0);
        #10;
        checkOutput("reset_hold_edge", 5'b00110, 2'd0, 32'd0);
        @(negedge clk);
        lock = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b1;
        modelReset();

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].l, tbl[i].b, tbl[i].rq, tbl[i].rd);
            checkOutput($sformatf("table_%0d", i), tbl[i].eo, tbl[i].es, m_stall);
            modelStep(modelOut(tbl[i].l, tbl[i].b, tbl[i].rq, tbl[i].rd), tbl[i].b, tbl[i].rq, tbl[i].rd);
        end

        // Asynchronous reset in the middle of MEM_WAIT.
        modelCycle("mw_enter", 0, 0, 1, 0);
        modelCycle("mw_hold", 0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_mw", 5'b00110, 2'd0, 32'd0);
        modelReset();
        lock = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        rst_n = 1'b1;
        handCycle("after_reset_mw", 0, 0, 0, 0, 5'b11001, 2'd0, 32'd0);

        // Three frozen cycles, then the ready cycle, then back to RUN.
        handCycle("mw3_c0", 0, 0, 1, 0, 5'b00000, 2'd0, 32'd0);
        handCycle("mw3_c1", 0, 0, 1, 0, 5'b00000, 2'd1, ON);
        handCycle("mw3_c2", 0, 0, 1, 0, 5'b00000, 2'd1, 2 * ON);
        handCycle("mw3_ready", 0, 0, 1, 1, 5'b11001, 2'd1, 3 * ON);
        handCycle("mw3_run", 0, 0, 0, 0, 5'b11001, 2'd0, 3 * ON);

        // Asynchronous reset in the middle of FLUSH leaves no pending flush.
        handCycle("fl_branch", 0, 1, 0, 0, 5'b11111, 2'd0, 3 * ON);
        handCycle("fl_first", 0, 0, 0, 0, 5'b11101, 2'd2, 3 * ON);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_fl", 5'b00110, 2'd0, 32'd0);
        modelReset();
        #1;
        rst_n = 1'b1;
        handCycle("after_reset_fl0", 0, 0, 0, 0, 5'b11001, 2'd0, 32'd0);
        handCycle("after_reset_fl1", 0, 0, 0, 0, 5'b11001, 2'd0, 32'd0);

        // Random traffic checked against the reference model.
        for (int n = 0; n < 3000; n++) begin
            modelCycle("random",
                       ($urandom_range(3) == 0),
                       ($urandom_range(5) == 0),
                       ($urandom_range(2) == 0),
                       ($urandom_range(1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
